// File: rtl/playback_timer.sv
// playback_timer: elapsed-seconds counter with seek, end-of-track limit and BCD digits
//   clk, reset (async, active-low)         clock and reset
//   count, clear                           run/pause, synchronous return to 0:00
//   seek_valid, seek_dir, seek_secs        one-cycle seek request (dir 1 = backward)
//   limit_secs                             track length, 0 = MAX_SECS
//   seconds0, seconds1, minutes            BCD display digits of elapsed (or remaining)
//   elapsed, tick, done                    binary seconds, per-second pulse, at-limit flag
//   PLAYBACK_TIMER_REMAINING_EN            adds show_remaining: digits show limit - elapsed
module playback_timer #(
   parameter int TICK_DIV   = 50000000,
   parameter int MIN_DIGITS = 1,
   parameter int SEEK_W     = 6,
   parameter int SECS_W     = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    count,
   input  logic                    clear,
   input  logic                    seek_valid,
   input  logic                    seek_dir,
   input  logic [SEEK_W-1:0]       seek_secs,
   input  logic [SECS_W-1:0]       limit_secs,
`ifdef PLAYBACK_TIMER_REMAINING_EN
   input  logic                    show_remaining,
`endif
   output logic [3:0]              seconds0,
   output logic [3:0]              seconds1,
   output logic [4*MIN_DIGITS-1:0] minutes,
   output logic [SECS_W-1:0]       elapsed,
   output logic                    tick,
   output logic                    done
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [SECS_W-1:0] MAX_SECS = SECS_W'(60 * 10**MIN_DIGITS - 1);
   typedef enum logic [1:0] {PAUSED, RUNNING, DONE} state_t;
   state_t state, state_n;
   logic [PW-1:0] pre, pre_n;
   logic [SECS_W-1:0] lim, el_n, disp, secs, mins;
   logic [SECS_W:0] e1, s1, nx;
   logic sec_ev;
   assign lim    = (limit_secs == '0 || limit_secs > MAX_SECS) ? MAX_SECS : limit_secs;
   assign sec_ev = state == RUNNING && pre == PW'(TICK_DIV - 1);
   assign e1     = {1'b0, elapsed};
   assign s1     = (SECS_W+1)'(seek_secs);
   // clear beats seek beats second event; the final clamp also pulls elapsed
   // back to the limit when limit_secs is lowered underneath it
   always_comb begin
      nx      = clear ? '0 : seek_valid ? (seek_dir ? (e1 >= s1 ? e1 - s1 : '0) : e1 + s1) : sec_ev ? e1 + (SECS_W+1)'(1) : e1;
      el_n    = nx > {1'b0, lim} ? lim : nx[SECS_W-1:0];
      state_n = el_n == lim ? DONE : count ? RUNNING : PAUSED;
      pre_n   = clear ? '0 : state != RUNNING ? pre : sec_ev ? '0 : pre + PW'(1);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= PAUSED;
         pre     <= '0;
         elapsed <= '0;
         tick    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         pre     <= pre_n;
         elapsed <= el_n;
         tick    <= sec_ev && !clear && !seek_valid;
         done    <= el_n == lim;
      end
`ifdef PLAYBACK_TIMER_REMAINING_EN
   assign disp = show_remaining ? (elapsed > lim ? '0 : lim - elapsed) : elapsed;
`else
   assign disp = elapsed;
`endif
   assign secs     = disp % SECS_W'(60);
   assign mins     = disp / SECS_W'(60);
   assign seconds0 = 4'(secs % SECS_W'(10));
   assign seconds1 = 4'(secs / SECS_W'(10));
   for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
      assign minutes[4*i +: 4] = 4'((mins / SECS_W'(10**i)) % SECS_W'(10));
   end
endmodule
